msg_bus_fifo: RTL and testbench

MSG_BUS_FIFO -- requirements
Module: msg_bus_fifo

---
 rtl/msg_bus_pkg.sv | 17 +
 rtl/msg_fifo.sv | 51 +++++
 rtl/msg_bus_fifo.sv | 97 +++++++++
 tb/tb_msg_bus_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_bus_pkg.sv
// Shared definitions for the inter-core message bus: opcode encodings and
// the sizing helper for core identifiers.
package msg_bus_pkg;

   typedef enum logic [1:0] {
      HALT_PAUSE = 2'b00,
      STOP       = 2'b01,
      CONTINUE   = 2'b10,
      DONE       = 2'b11
   } opcode_t;

   // Identifier width for a given core count; never narrower than one bit.
   function automatic int core_id_width(input int num_cores);
      return (num_cores > 1) ? $clog2(num_cores) : 1;
   endfunction

endpackage

// File: rtl/msg_fifo.sv
// Single-clock receive FIFO holding {src_id, instr} entries for one core.
// The head reads as zero while empty so idle outputs stay clean.
module msg_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int COUNT_W = PTR_W + 1;

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [COUNT_W-1:0] count;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == COUNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointers wrap on their own because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/msg_bus_fifo.sv
// Round-robin message bus: one sender per cycle multicasts {src, instr} into
// the receive FIFOs of its destination cores.
module msg_bus_fifo
   import msg_bus_pkg::*;
#(
   parameter  int NUM_CORES     = 4,
   parameter  int INSTR_WIDTH   = 2,
   parameter  int FIFO_DEPTH    = 4,
   localparam int CORE_ID_WIDTH = core_id_width(NUM_CORES)
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [NUM_CORES-1:0]               send_valid,
   input  logic [NUM_CORES*NUM_CORES-1:0]     send_dst_mask,
   input  logic [NUM_CORES*INSTR_WIDTH-1:0]   send_instr,
   output logic [NUM_CORES-1:0]               send_ready,
   output logic [NUM_CORES-1:0]               recv_valid,
   input  logic [NUM_CORES-1:0]               recv_ready,
   output logic [NUM_CORES*CORE_ID_WIDTH-1:0] recv_src,
   output logic [NUM_CORES*INSTR_WIDTH-1:0]   recv_instr
);

   localparam int ENTRY_W = CORE_ID_WIDTH + INSTR_WIDTH;

   logic [NUM_CORES-1:0]     eff_mask [NUM_CORES];
   logic [NUM_CORES-1:0]     full_vec;
   logic [NUM_CORES-1:0]     empty_vec;
   logic [NUM_CORES-1:0]     eligible;
   logic [NUM_CORES-1:0]     grant;
   logic [NUM_CORES-1:0]     push_vec;
   logic [CORE_ID_WIDTH-1:0] priority_ptr;
   logic [CORE_ID_WIDTH-1:0] winner;
   logic                     granted;
   logic [ENTRY_W-1:0]       push_entry;
   int                       idx;

   // A sender may only compete when every FIFO it targets has room right now;
   // a same-cycle pop is deliberately not counted as free space.
   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         eff_mask[i]    = send_dst_mask[i*NUM_CORES +: NUM_CORES];
         eff_mask[i][i] = 1'b0;
         eligible[i]    = send_valid[i] && ((eff_mask[i] & full_vec) == '0);
      end
   end

   always_comb begin
      grant   = '0;
      winner  = '0;
      granted = 1'b0;
      idx     = 0;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = int'(priority_ptr) + k;
         if (idx >= NUM_CORES) idx = idx - NUM_CORES;
         if (reset_n && !granted && eligible[idx]) begin
            granted    = 1'b1;
            winner     = CORE_ID_WIDTH'(idx);
            grant[idx] = 1'b1;
         end
      end
   end

   assign send_ready = grant;
   assign push_vec   = granted ? eff_mask[winner] : '0;
   assign push_entry = {winner, send_instr[int'(winner)*INSTR_WIDTH +: INSTR_WIDTH]};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         priority_ptr <= '0;
      end else if (granted) begin
         priority_ptr <= (int'(winner) == NUM_CORES - 1) ? '0 : winner + 1'b1;
      end
   end

   for (genvar j = 0; j < NUM_CORES; j++) begin : g_rx
      logic [ENTRY_W-1:0] head;

      msg_fifo #(
         .WIDTH (ENTRY_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .reset_n (reset_n),
         .push    (push_vec[j]),
         .din     (push_entry),
         .pop     (recv_ready[j]),
         .full    (full_vec[j]),
         .empty   (empty_vec[j]),
         .dout    (head)
      );

      assign recv_valid[j]                                  = !empty_vec[j];
      assign recv_src[j*CORE_ID_WIDTH +: CORE_ID_WIDTH]     = head[ENTRY_W-1 -: CORE_ID_WIDTH];
      assign recv_instr[j*INSTR_WIDTH +: INSTR_WIDTH]       = head[INSTR_WIDTH-1:0];
   end

endmodule

// File: tb/tb_msg_bus_fifo.sv
// Directed bench for msg_bus_fifo with four cores and two-entry FIFOs;
// expected values are worked out by hand for each scenario.
module tb_msg_bus_fifo;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int CW = 2;

   logic          clk;
   logic          reset_n;
   logic [N-1:0]  send_valid;
   logic [N*N-1:0] send_dst_mask;
   logic [N*IW-1:0] send_instr;
   logic [N-1:0]  send_ready;
   logic [N-1:0]  recv_valid;
   logic [N-1:0]  recv_ready;
   logic [N*CW-1:0] recv_src;
   logic [N*IW-1:0] recv_instr;

   int checks = 0;
   int errors = 0;

   msg_bus_fifo #(
      .NUM_CORES   (N),
      .INSTR_WIDTH (IW),
      .FIFO_DEPTH  (2)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .send_valid    (send_valid),
      .send_dst_mask (send_dst_mask),
      .send_instr    (send_instr),
      .send_ready    (send_ready),
      .recv_valid    (recv_valid),
      .recv_ready    (recv_ready),
      .recv_src      (recv_src),
      .recv_instr    (recv_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Senders must keep a request and its payload steady until it is granted.
   logic [N-1:0]    pend;
   logic [N*N-1:0]  pend_mask;
   logic [N*IW-1:0] pend_instr;

   always @(posedge clk) begin
      if (reset_n !== 1'b1) begin
         pend <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
               checks++;
               if (send_valid[i] !== 1'b1 || send_dst_mask[i*N +: N] !== pend_mask[i*N +: N] ||
                   send_instr[i*IW +: IW] !== pend_instr[i*IW +: IW]) begin
                  errors++;
                  $display("[TB] FAIL hold_until_grant core %0d: valid=%b mask=%b instr=%b, required valid=1 mask=%b instr=%b",
                           i, send_valid[i], send_dst_mask[i*N +: N], send_instr[i*IW +: IW],
                           pend_mask[i*N +: N], pend_instr[i*IW +: IW]);
               end
            end
         end
         pend       <= send_valid & ~send_ready;
         pend_mask  <= send_dst_mask;
         pend_instr <= send_instr;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_send(input int i, input logic v, input logic [N-1:0] m, input logic [IW-1:0] ins);
      send_valid[i]          = v;
      send_dst_mask[i*N +: N] = m;
      send_instr[i*IW +: IW] = ins;
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      send_valid    = '0;
      send_dst_mask = '0;
      send_instr    = '0;
      recv_ready    = '0;
      set_send(1, 1'b1, 4'b0001, 2'b01);
      set_send(3, 1'b1, 4'b0001, 2'b11);
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_send_ready: got %b, expected 0000", send_ready); end
      checks++;
      if (recv_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_recv_valid: got %b, expected 0000", recv_valid); end
      checks++;
      if (recv_src !== 8'h00 || recv_instr !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_recv_data: got src=%h instr=%h, expected 00/00", recv_src, recv_instr);
      end
      send_valid = '0;
      reset_n    = 1'b1;
      next_cycle();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_grant;
      logic [N-1:0] exp_valid;
      int           dst;
      recv_ready = 4'b1111;
      set_send(0, 1'b1, 4'b0010, 2'd0);
      set_send(1, 1'b1, 4'b0100, 2'd1);
      set_send(2, 1'b1, 4'b1000, 2'd2);
      set_send(3, 1'b1, 4'b0001, 2'd3);
      for (int c = 0; c < 9; c++) begin
         exp_grant = 4'b0001 << (c % 4);
         dst       = (c + 1) % 4;
         exp_valid = 4'b0001 << dst;
         @(negedge clk);
         checks++;
         if (send_ready !== exp_grant) begin
            errors++; $display("[TB] FAIL rr_grant cycle %0d: got %b, expected %b", c, send_ready, exp_grant);
         end
         next_cycle();
         checks++;
         if (recv_valid !== exp_valid) begin
            errors++; $display("[TB] FAIL rr_recv_valid cycle %0d: got %b, expected %b", c, recv_valid, exp_valid);
         end
         checks++;
         if (recv_src[dst*CW +: CW] !== CW'(c % 4)) begin
            errors++; $display("[TB] FAIL rr_recv_src cycle %0d: got %0d, expected %0d", c, recv_src[dst*CW +: CW], c % 4);
         end
         if (c >= 5) send_valid[c % 4] = 1'b0;
      end
      next_cycle();
      recv_ready = '0;
      checks++;
      if (recv_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rr_drained: got %b, expected 0000", recv_valid); end
   endtask

   task automatic test_single();
      set_send(1, 1'b1, 4'b0100, 2'b10);
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0010) begin errors++; $display("[TB] FAIL single_grant: got %b, expected 0010", send_ready); end
      checks++;
      if (recv_valid !== 4'b0000) begin errors++; $display("[TB] FAIL single_no_bypass: got %b, expected 0000", recv_valid); end
      next_cycle();
      send_valid[1] = 1'b0;
      checks++;
      if (recv_valid !== 4'b0100) begin errors++; $display("[TB] FAIL single_recv_valid: got %b, expected 0100", recv_valid); end
      checks++;
      if (recv_src[5:4] !== 2'd1 || recv_instr[5:4] !== 2'b10) begin
         errors++; $display("[TB] FAIL single_recv_data: got src=%0d instr=%b, expected src=1 instr=10", recv_src[5:4], recv_instr[5:4]);
      end
      next_cycle();
      checks++;
      if (recv_valid !== 4'b0100 || recv_instr[5:4] !== 2'b10) begin
         errors++; $display("[TB] FAIL single_head_stable: got valid=%b instr=%b, expected 0100/10", recv_valid, recv_instr[5:4]);
      end
      recv_ready = 4'b0100;
      next_cycle();
      recv_ready = '0;
      checks++;
      if (recv_valid !== 4'b0000) begin errors++; $display("[TB] FAIL single_pop: got %b, expected 0000", recv_valid); end
   endtask

   task automatic test_broadcast();
      set_send(0, 1'b1, 4'b1111, 2'b11);
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0001) begin errors++; $display("[TB] FAIL bcast_grant: got %b, expected 0001", send_ready); end
      next_cycle();
      send_valid[0] = 1'b0;
      checks++;
      if (recv_valid !== 4'b1110) begin errors++; $display("[TB] FAIL bcast_recv_valid: got %b, expected 1110", recv_valid); end
      checks++;
      if (recv_src !== 8'h00 || recv_instr !== 8'b11_11_11_00) begin
         errors++; $display("[TB] FAIL bcast_recv_data: got src=%b instr=%b, expected 00000000/11111100", recv_src, recv_instr);
      end
      recv_ready = 4'b1111;
      next_cycle();
      recv_ready = '0;
      checks++;
      if (recv_valid !== 4'b0000) begin errors++; $display("[TB] FAIL bcast_pop: got %b, expected 0000", recv_valid); end
   endtask

   task automatic test_blocking();
      set_send(2, 1'b1, 4'b1000, 2'b01);
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0100) begin errors++; $display("[TB] FAIL fill1_grant: got %b, expected 0100", send_ready); end
      next_cycle();
      set_send(2, 1'b1, 4'b1000, 2'b10);
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0100) begin errors++; $display("[TB] FAIL fill2_grant: got %b, expected 0100", send_ready); end
      next_cycle();
      send_valid[2] = 1'b0;
      set_send(0, 1'b1, 4'b1000, 2'b11);
      set_send(1, 1'b1, 4'b0001, 2'b00);
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0010) begin errors++; $display("[TB] FAIL blocked_other_granted: got %b, expected 0010", send_ready); end
      next_cycle();
      send_valid[1] = 1'b0;
      checks++;
      if (recv_valid !== 4'b1001 || recv_src[1:0] !== 2'd1 || recv_instr[7:6] !== 2'b01) begin
         errors++; $display("[TB] FAIL blocked_queues: got valid=%b src0=%0d instr3=%b, expected 1001/1/01",
                            recv_valid, recv_src[1:0], recv_instr[7:6]);
      end
      recv_ready = 4'b1000;
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0000) begin errors++; $display("[TB] FAIL blocked_same_cycle_pop: got %b, expected 0000", send_ready); end
      next_cycle();
      recv_ready = '0;
      checks++;
      if (recv_instr[7:6] !== 2'b10 || recv_src[7:6] !== 2'd2) begin
         errors++; $display("[TB] FAIL fifo_order: got src=%0d instr=%b, expected 2/10", recv_src[7:6], recv_instr[7:6]);
      end
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0001) begin errors++; $display("[TB] FAIL unblocked_grant: got %b, expected 0001", send_ready); end
      next_cycle();
      send_valid[0] = 1'b0;
      checks++;
      if (recv_valid !== 4'b1001 || recv_instr[7:6] !== 2'b10) begin
         errors++; $display("[TB] FAIL unblocked_queues: got valid=%b instr3=%b, expected 1001/10", recv_valid, recv_instr[7:6]);
      end
   endtask

   task automatic test_reset_mid();
      set_send(2, 1'b1, 4'b0001, 2'b00);
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0100) begin errors++; $display("[TB] FAIL pre_reset_grant: got %b, expected 0100", send_ready); end
      next_cycle();
      send_valid[2] = 1'b0;
      reset_n       = 1'b0;
      set_send(1, 1'b1, 4'b0100, 2'b01);
      set_send(3, 1'b1, 4'b0010, 2'b11);
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_holds_ready: got %b, expected 0000", send_ready); end
      next_cycle();
      reset_n = 1'b1;
      checks++;
      if (recv_valid !== 4'b0000 || recv_src !== 8'h00 || recv_instr !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_flush: got valid=%b src=%h instr=%h, expected 0000/00/00", recv_valid, recv_src, recv_instr);
      end
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0010) begin errors++; $display("[TB] FAIL post_reset_lowest: got %b, expected 0010", send_ready); end
      next_cycle();
      send_valid[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b1000) begin errors++; $display("[TB] FAIL post_reset_next: got %b, expected 1000", send_ready); end
      next_cycle();
      send_valid[3] = 1'b0;
   endtask

   task automatic test_self_only();
      recv_ready = 4'b1111;
      next_cycle();
      recv_ready = '0;
      checks++;
      if (recv_valid !== 4'b0000) begin errors++; $display("[TB] FAIL self_pre_drain: got %b, expected 0000", recv_valid); end
      set_send(2, 1'b1, 4'b0100, 2'b11);
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0100) begin errors++; $display("[TB] FAIL self_grant: got %b, expected 0100", send_ready); end
      next_cycle();
      send_valid[2] = 1'b0;
      checks++;
      if (recv_valid !== 4'b0000) begin errors++; $display("[TB] FAIL self_no_write: got %b, expected 0000", recv_valid); end
      set_send(0, 1'b1, 4'b0010, 2'd0);
      set_send(1, 1'b1, 4'b0100, 2'd1);
      set_send(3, 1'b1, 4'b0001, 2'd3);
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b1000) begin errors++; $display("[TB] FAIL self_ptr_advanced: got %b, expected 1000", send_ready); end
      next_cycle();
      send_valid[3] = 1'b0;
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0001) begin errors++; $display("[TB] FAIL self_wrap_grant: got %b, expected 0001", send_ready); end
      next_cycle();
      send_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (send_ready !== 4'b0010) begin errors++; $display("[TB] FAIL self_last_grant: got %b, expected 0010", send_ready); end
      next_cycle();
      send_valid[1] = 1'b0;
      checks++;
      if (recv_valid !== 4'b0111) begin errors++; $display("[TB] FAIL self_final_queues: got %b, expected 0111", recv_valid); end
   endtask

   initial begin
      reset_n       = 1'b0;
      send_valid    = '0;
      send_dst_mask = '0;
      send_instr    = '0;
      recv_ready    = '0;
      test_reset();
      test_round_robin();
      test_single();
      test_broadcast();
      test_blocking();
      test_reset_mid();
      test_self_only();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
